// File: rtl/ssd1306_spi_sink.sv
// ssd1306_spi_sink: write-only SSD1306 emulation fed by a mode-0 SPI master.
// Deserialises bytes, decodes commands and drives a single-cycle framebuffer write port.
module ssd1306_spi_sink #(
  parameter int COLS          = 128,
  parameter int PAGES         = 8,
  parameter int FB_ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  input  logic                     mosi,
  input  logic                     cs_n,
  input  logic                     dc,
  output logic                     fb_we,
  output logic [FB_ADDR_WIDTH-1:0] fb_addr,
  output logic [7:0]               fb_data,
  output logic                     display_on,
  output logic                     invert,
  output logic [7:0]               contrast
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;
  state_t state, state_next;

  logic [1:0]    scl_sync, mosi_sync, cs_sync, dc_sync;
  logic          scl_prev, scl_rise;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          byte_done, done_dc;
  logic          byte_valid, rx_dc;
  logic [7:0]    rx_byte;
  logic          cmd_valid, data_valid;
  logic [7:0]    pend_cmd;
  logic [1:0]    mode;
  logic [CW-1:0] col, col_start, col_end, col_next;
  logic [PW-1:0] page, page_start, page_end, page_next;
  logic [FB_ADDR_WIDTH-1:0] addr_calc;
  logic set_display, set_invert, set_col_lo, set_col_hi, set_page, latch_cmd;
  logic set_contrast, set_mode, set_col_start, set_col_end, set_page_start, set_page_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      scl_prev  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[0], scl};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs_n};
      dc_sync   <= {dc_sync[0], dc};
      scl_prev  <= scl_sync[1];
    end
  end

  assign scl_rise = scl_sync[1] & ~scl_prev;

  // A completed byte is flagged on the 8th shift and handed to the parser one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      byte_done  <= 1'b0;
      done_dc    <= 1'b0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'h00;
      rx_dc      <= 1'b0;
    end else begin
      byte_done  <= 1'b0;
      byte_valid <= byte_done;
      if (byte_done) begin
        rx_byte <= shift;
        rx_dc   <= done_dc;
      end
      if (cs_sync[1]) begin
        bit_cnt <= 3'd0;
      end else if (scl_rise) begin
        shift   <= {shift[6:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          done_dc   <= dc_sync[1];
        end
      end
    end
  end

  assign cmd_valid  = byte_valid & ~rx_dc;
  assign data_valid = byte_valid & rx_dc;

  function automatic logic takes_arg(input logic [7:0] c);
    case (c)
      8'h81, 8'h20, 8'h8D, 8'hD5, 8'hA8, 8'hD3, 8'hDA, 8'hD9, 8'hDB,
      8'h21, 8'h22: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cmd_valid) begin
      case (state)
        IDLE:    if (takes_arg(rx_byte)) state_next = ARG1;
        ARG1:    state_next = (pend_cmd == 8'h21 || pend_cmd == 8'h22) ? ARG2 : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Data bytes never reach this decode, so they cannot disturb argument collection.
  always_comb begin
    set_display    = 1'b0;
    set_invert     = 1'b0;
    set_col_lo     = 1'b0;
    set_col_hi     = 1'b0;
    set_page       = 1'b0;
    latch_cmd      = 1'b0;
    set_contrast   = 1'b0;
    set_mode       = 1'b0;
    set_col_start  = 1'b0;
    set_col_end    = 1'b0;
    set_page_start = 1'b0;
    set_page_end   = 1'b0;
    if (cmd_valid) begin
      case (state)
        IDLE: begin
          set_display = (rx_byte[7:1] == 7'h57);
          set_invert  = (rx_byte[7:1] == 7'h53);
          set_col_lo  = (rx_byte[7:4] == 4'h0);
          set_col_hi  = (rx_byte[7:3] == 5'b00010);
          set_page    = (rx_byte[7:3] == 5'b10110);
          latch_cmd   = takes_arg(rx_byte);
        end
        ARG1: begin
          set_contrast   = (pend_cmd == 8'h81);
          set_mode       = (pend_cmd == 8'h20);
          set_col_start  = (pend_cmd == 8'h21);
          set_page_start = (pend_cmd == 8'h22);
        end
        ARG2: begin
          set_col_end  = (pend_cmd == 8'h21);
          set_page_end = (pend_cmd == 8'h22);
        end
        default: ;
      endcase
    end
  end

  // Inverted ranges fall out naturally: the pointer wraps at its width until it hits the end.
  always_comb begin
    col_next  = col;
    page_next = page;
    case (mode)
      2'd0: begin
        if (col == col_end) begin
          col_next  = col_start;
          page_next = (page == page_end) ? page_start : page + PW'(1);
        end else begin
          col_next = col + CW'(1);
        end
      end
      2'd1: begin
        if (page == page_end) begin
          page_next = page_start;
          col_next  = (col == col_end) ? col_start : col + CW'(1);
        end else begin
          page_next = page + PW'(1);
        end
      end
      default: col_next = (col == col_end) ? col_start : col + CW'(1);
    endcase
  end

  assign addr_calc = FB_ADDR_WIDTH'(page) * FB_ADDR_WIDTH'(COLS) + FB_ADDR_WIDTH'(col);

  // The pointer advances the cycle after the write strobe, keeping fb_addr stable while fb_we is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= 8'h00;
      display_on <= 1'b0;
      invert     <= 1'b0;
      contrast   <= 8'h7F;
      pend_cmd   <= 8'h00;
      mode       <= 2'd2;
      col        <= '0;
      page       <= '0;
      col_start  <= '0;
      col_end    <= CW'(COLS - 1);
      page_start <= '0;
      page_end   <= PW'(PAGES - 1);
    end else begin
      fb_we <= 1'b0;
      if (data_valid) begin
        fb_we   <= 1'b1;
        fb_addr <= addr_calc;
        fb_data <= rx_byte;
      end
      if (fb_we) begin
        col  <= col_next;
        page <= page_next;
      end
      if (set_display)    display_on <= rx_byte[0];
      if (set_invert)     invert     <= rx_byte[0];
      if (set_col_lo)     col[3:0]   <= rx_byte[3:0];
      if (set_col_hi)     col[CW-1:4] <= rx_byte[CW-5:0];
      if (set_page)       page       <= rx_byte[PW-1:0];
      if (latch_cmd)      pend_cmd   <= rx_byte;
      if (set_contrast)   contrast   <= rx_byte;
      if (set_mode)       mode       <= (rx_byte[1:0] == 2'd3) ? 2'd2 : rx_byte[1:0];
      if (set_col_start)  col_start  <= rx_byte[CW-1:0];
      if (set_page_start) page_start <= rx_byte[PW-1:0];
      if (set_col_end) begin
        col_end <= rx_byte[CW-1:0];
        col     <= col_start;
      end
      if (set_page_end) begin
        page_end <= rx_byte[PW-1:0];
        page     <= page_start;
      end
    end
  end

endmodule
